// File: rtl/flopen_pipe.sv
// ============================================================================
// Module   : flopen_pipe
// Purpose  : Elastic valid/ready pipeline of DEPTH enabled-flop stages with
//            bubble collapse, synchronous flush and an occupancy count.
//            Define FLOPEN_PIPE_RSTDATA_EN to reset the data flops to RESET_VAL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flopen_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH:0]   w_en;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CW-1:0]    r_count;

    // A stage may load when it is empty or its successor is loading too.
    always_comb begin
        w_en        = '0;
        w_en[DEPTH] = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            w_en[i] = ~w_v[i] | w_en[i+1];
        end
    end

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             r_v;
        logic [WIDTH-1:0] r_d;
        logic             w_v_nxt;
        logic [WIDTH-1:0] w_d_nxt;

        if (gi == 0) begin : g_head
            assign w_v_nxt = in_valid;
            assign w_d_nxt = in_data;
        end else begin : g_body
            assign w_v_nxt = w_v[gi-1];
            assign w_d_nxt = w_d[gi-1];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_v <= 1'b0;
            end else if (flush) begin
                r_v <= 1'b0;
            end else if (w_en[gi]) begin
                r_v <= w_v_nxt;
            end
        end

`ifdef FLOPEN_PIPE_RSTDATA_EN
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_d <= RESET_VAL;
            end else if (w_en[gi]) begin
                r_d <= w_d_nxt;
            end
        end
`else
        // Data is qualified by the valid bit, so it may load freely during flush.
        always_ff @(posedge clk) begin
            if (w_en[gi]) begin
                r_d <= w_d_nxt;
            end
        end
`endif

        assign w_v[gi] = r_v;
        assign w_d[gi] = r_d;
    end

`ifndef FLOPEN_PIPE_RSTDATA_EN
    logic w_unused_rstval;
    assign w_unused_rstval = ^RESET_VAL;
`endif

    assign in_ready   = w_en[0] & ~flush;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = w_v[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_flopen_pipe.sv
// ============================================================================
// Module   : tb_flopen_pipe
// Purpose  : Self-checking bench for flopen_pipe (DEPTH=3 main, DEPTH=1 reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flopen_pipe;

    localparam int W = 8;
    localparam int D = 3;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   count;

    logic         rst1_n, fl1, iv1, ir1, ov1, or1;
    logic [7:0]   id1, od1;
    logic [0:0]   c1;

    flopen_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'hA5)) u_dut (
        .clk(clk), .reset_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    flopen_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset_n(rst1_n), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .count(c1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: ordered list of in-flight beats with their stage index.
    logic [7:0] mq_d[$];
    int         mq_p[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit use_exp);
        int   np[$];
        int   lim;
        int   n;
        logic exp_ir;
        logic exp_ov;
        in_valid  = v.iv;
        in_data   = v.d;
        out_ready = v.ordy;
        flush     = v.fl;
        @(negedge clk);
        // A beat advances one stage if the slot ahead is free after the beat
        // in front of it has moved; the oldest beat may exit when out_ready.
        n   = mq_p.size();
        lim = out_ready ? D + 1 : D;
        for (int j = 0; j < n; j++) begin
            int p;
            int q;
            p = mq_p[j];
            q = (p + 1 < lim) ? p + 1 : p;
            np.push_back(q);
            lim = q;
        end
        exp_ir = !flush && (n == 0 || mq_p[n-1] != 0 || np[n-1] != 0);
        exp_ov = (n > 0) && (mq_p[0] == D - 1);
        chk("model_in_ready", 32'(in_ready), 32'(exp_ir));
        chk("model_out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) chk("model_out_data", 32'(out_data), 32'(mq_d[0]));
        chk("model_count", 32'(count), 32'(n));
        if (use_exp) begin
            chk("vec_in_ready", 32'(in_ready), 32'(v.e_ir));
            chk("vec_out_valid", 32'(out_valid), 32'(v.e_ov));
            if (v.e_ov) chk("vec_out_data", 32'(out_data), 32'(v.e_od));
            chk("vec_count", 32'(count), 32'(v.e_cnt));
        end
        @(posedge clk);
        if (flush) begin
            mq_d.delete();
            mq_p.delete();
        end else begin
            for (int j = 0; j < n; j++) mq_p[j] = np[j];
            if (n > 0 && mq_p[0] == D) begin
                void'(mq_p.pop_front());
                void'(mq_d.pop_front());
            end
            if (in_valid && exp_ir) begin
                mq_d.push_back(in_data);
                mq_p.push_back(0);
            end
        end
        #1;
    endtask

    vec_t tbl[18];
    vec_t v;

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
        tbl[4]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 2'd3};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd3};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1};
        tbl[9]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
        tbl[11] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2};
        tbl[14] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2};
        tbl[15] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 2'd3};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};

        rst_n = 1'b0; rst1_n = 1'b0;
        fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = 8'h00;

        // Reset held with random inputs
        for (int c = 0; c < 4; c++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            flush     = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'(!flush));
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_count", 32'(count), 32'd0);
`ifdef FLOPEN_PIPE_RSTDATA_EN
        chk("rel_out_data", 32'(out_data), 32'hA5);
`endif
        @(posedge clk); #1;

        // Streaming 01..0A with out_ready held high
        for (int c = 0; c < 13; c++) begin
            int acc;
            int del;
            acc     = (c < 10) ? c : 10;
            del     = (c > 3) ? c - 3 : 0;
            v.iv    = (c < 10);
            v.d     = 8'(c + 1);
            v.ordy  = 1'b1;
            v.fl    = 1'b0;
            v.e_ir  = 1'b1;
            v.e_ov  = (c >= 3);
            v.e_od  = 8'(c - 2);
            v.e_cnt = 2'(acc - del);
            step(v, 1'b1);
        end

        // Stall/fill, drain, bubble collapse, flush
        for (int k = 0; k < 18; k++) step(tbl[k], 1'b1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            v.iv   = 1'($urandom);
            v.d    = 8'($urandom);
            v.ordy = ($urandom_range(0, 9) < 6);
            v.fl   = ($urandom_range(0, 24) == 0);
            step(v, 1'b0);
        end
        in_valid = 1'b0; flush = 1'b0;

        // DEPTH=1: asynchronous reset between edges
        iv1 = 1'b1; id1 = 8'h5A; or1 = 1'b0;
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("d1_ov_loaded", 32'(ov1), 32'd1);
        chk("d1_count_loaded", 32'(c1), 32'd1);
        chk("d1_od_loaded", 32'(od1), 32'h5A);
        #1 rst1_n = 1'b0;
        #1;
        chk("d1_async_ov", 32'(ov1), 32'd0);
        chk("d1_async_count", 32'(c1), 32'd0);
        #1 rst1_n = 1'b1;
        iv1 = 1'b1; id1 = 8'hC3;
        @(negedge clk);
        chk("d1_post_ready", 32'(ir1), 32'd1);
        chk("d1_post_ov", 32'(ov1), 32'd0);
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("d1_lat_ov", 32'(ov1), 32'd1);
        chk("d1_lat_od", 32'(od1), 32'hC3);
        chk("d1_lat_count", 32'(c1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
